// File: rtl/pwm_generator.sv
// Reloadable period counter with duty comparator; produces a PWM waveform and a
// period tick, with double-buffered settings adopted only at period boundaries.
module pwm_generator #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] base_in,
    input  logic [W-1:0] duty_in,
    input  logic         upd,
    output logic         pwm,
    output logic         period_tick,
    output logic         upd_ack,
    output logic         busy
);

    localparam logic [W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] base_act_q, base_act_d;
    logic [W-1:0] duty_act_q, duty_act_d;
    logic [W-1:0] base_pend_q, base_pend_d;
    logic [W-1:0] duty_pend_q, duty_pend_d;
    logic         pend_q, pend_d;
    logic         upd_ack_q, upd_ack_d;

    logic         wrap_c;
    logic         start_c;
    logic [W-1:0] phase_c;

    assign wrap_c  = (cnt_q == CNT_MAX);
    assign start_c = (state_q == IDLE) && en;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_act_q  <= '0;
            duty_act_q  <= '0;
            base_pend_q <= '0;
            duty_pend_q <= '0;
            pend_q      <= 1'b0;
            upd_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_act_q  <= base_act_d;
            duty_act_q  <= duty_act_d;
            base_pend_q <= base_pend_d;
            duty_pend_q <= duty_pend_d;
            pend_q      <= pend_d;
            upd_ack_q   <= upd_ack_d;
        end
    end

    // Next-state, counting and settings hand-over
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_act_d  = base_act_q;
        duty_act_d  = duty_act_q;
        base_pend_d = base_pend_q;
        duty_pend_d = duty_pend_q;
        pend_d      = pend_q;
        upd_ack_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    base_act_d = base_in;
                    duty_act_d = duty_in;
                    cnt_d      = base_in;
                    pend_d     = 1'b0;
                    upd_ack_d  = pend_q | upd;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = DRAIN;
                end
                if (wrap_c) begin
                    if (pend_q) begin
                        base_act_d = base_pend_q;
                        duty_act_d = duty_pend_q;
                        cnt_d      = base_pend_q;
                        pend_d     = 1'b0;
                        upd_ack_d  = 1'b1;
                    end else begin
                        cnt_d = base_act_q;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end
                if (wrap_c) begin
                    // Pending settings stay parked while draining
                    if (en) begin
                        cnt_d = base_act_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A request coinciding with a wrap is held for the following boundary
        if (upd) begin
            base_pend_d = base_in;
            duty_pend_d = duty_in;
            if (!start_c) begin
                pend_d = 1'b1;
            end
        end
    end

    assign phase_c     = cnt_q - base_act_q;
    assign busy        = (state_q != IDLE);
    assign period_tick = busy & wrap_c;
    assign pwm         = busy & (phase_c < duty_act_q);
    assign upd_ack     = upd_ack_q;

endmodule
